// File: rtl/mul_arb_pkg.sv
// mul_arb_pkg: shared definitions for the multiplier arbiter.
//   - default NREQ / W / TIMEOUT values
//   - FSM state enum (IDLE, ISSUE, WAIT, RESP)
package mul_arb_pkg;

  localparam int NREQ_DEF    = 4;
  localparam int W_DEF       = 8;
  localparam int TIMEOUT_DEF = 63;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_e;

endpackage

// File: rtl/mul_arb_rr.sv
// mul_arb_rr: combinational round-robin pick.
// Finds the first set request at or after ptr_i, wrapping cyclically.
// Ports:
//   req_i   [NREQ-1:0]  request levels
//   ptr_i   [IDXW-1:0]  search start index (always < NREQ)
//   valid_o             at least one request is set
//   idx_o   [IDXW-1:0]  index of the winning requester (0 when !valid_o)
module mul_arb_rr
  import mul_arb_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int IDXW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDXW-1:0] ptr_i,
  output logic            valid_o,
  output logic [IDXW-1:0] idx_o
);

  // One spare bit so ptr + offset cannot overflow before the wrap.
  logic [IDXW:0]   sum;
  logic [IDXW-1:0] cand;

  // Walk offsets from farthest to nearest so the nearest hit wins.
  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    sum     = '0;
    cand    = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      sum = {1'b0, ptr_i} + (IDXW + 1)'(k);
      if (sum >= (IDXW + 1)'(NREQ)) begin
        sum = sum - (IDXW + 1)'(NREQ);
      end
      cand = sum[IDXW-1:0];
      if (req_i[cand]) begin
        valid_o = 1'b1;
        idx_o   = cand;
      end
    end
  end

endmodule

// File: rtl/mul_arbiter.sv
// mul_arbiter: round-robin arbiter sharing one external multiplier among
// NREQ requesters.
//
// State table:
//   IDLE  | waiting for a request; picks owner, latches its operands
//   ISSUE | mul_bgn pulse to the multiplier
//   WAIT  | waiting for mul_done (or timeout when enabled)
//   RESP  | one-cycle ack[gnt_id] with the latched product
//
// Ports:
//   clk, rst_b          clock, synchronous active-low reset
//   req   [NREQ-1:0]    request levels
//   opa, opb            packed operands, slice i = requester i
//   ack   [NREQ-1:0]    one-hot completion pulse
//   result [2W-1:0]     product, meaningful while ack != 0
//   gnt_id              current owner index
//   mul_bgn             start pulse to the multiplier
//   mul_x, mul_y        operands to the multiplier
//   mul_done, mul_res   multiplier completion and product
//   timeout_err         set with ack when the wait timed out
//
// Build option: define MUL_ARB_TIMEOUT_EN to abort WAIT after TIMEOUT cycles
// with result 0 and timeout_err set. Without it WAIT never times out and
// timeout_err is constant 0.
module mul_arbiter
  import mul_arb_pkg::*;
#(
  parameter int NREQ    = NREQ_DEF,
  parameter int W       = W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                      clk,
  input  logic                      rst_b,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ*W-1:0]         opa,
  input  logic [NREQ*W-1:0]         opb,
  output logic [NREQ-1:0]           ack,
  output logic [2*W-1:0]            result,
  output logic [$clog2(NREQ)-1:0]   gnt_id,
  output logic                      mul_bgn,
  output logic [W-1:0]              mul_x,
  output logic [W-1:0]              mul_y,
  input  logic                      mul_done,
  input  logic [2*W-1:0]            mul_res,
  output logic                      timeout_err
);

  localparam int IDXW = $clog2(NREQ);

  arb_state_e      state_q, state_d;
  logic [IDXW-1:0] ptr_q, ptr_d;
  logic [IDXW-1:0] gnt_q, gnt_d;
  logic [W-1:0]    x_q, x_d;
  logic [W-1:0]    y_q, y_d;
  logic [2*W-1:0]  res_q, res_d;

  logic            pick_vld;
  logic [IDXW-1:0] pick_idx;
  logic            to_hit;

  mul_arb_rr #(
    .NREQ (NREQ),
    .IDXW (IDXW)
  ) u_rr (
    .req_i   (req),
    .ptr_i   (ptr_q),
    .valid_o (pick_vld),
    .idx_o   (pick_idx)
  );

`ifdef MUL_ARB_TIMEOUT_EN
  localparam int CNTW = $clog2(TIMEOUT + 1);

  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            to_q, to_d;

  // Last permitted WAIT cycle with no completion: give up.
  assign to_hit = (state_q == WAIT) && !mul_done &&
                  (cnt_q == CNTW'(TIMEOUT - 1));

  always_comb begin
    cnt_d = '0;
    if (state_q == WAIT) begin
      cnt_d = cnt_q + CNTW'(1);
    end
    // Registered so it lines up with the RESP cycle that follows.
    to_d = to_hit;
  end

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      cnt_q <= '0;
      to_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      to_q  <= to_d;
    end
  end

  assign timeout_err = to_q && (state_q == RESP);
`else
  assign to_hit = 1'b0;
  // Always 0 for any legal TIMEOUT; keeps the parameter referenced in
  // this build so both builds share one parameter list.
  assign timeout_err = (TIMEOUT < 0);
`endif

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    x_d     = x_q;
    y_d     = y_q;
    res_d   = res_q;
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          gnt_d   = pick_idx;
          x_d     = opa[pick_idx*W +: W];
          y_d     = opb[pick_idx*W +: W];
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        state_d = WAIT;
      end
      WAIT: begin
        // A completion in the same cycle as the timeout still wins.
        if (mul_done) begin
          res_d   = mul_res;
          state_d = RESP;
        end else if (to_hit) begin
          res_d   = '0;
          state_d = RESP;
        end
      end
      RESP: begin
        ptr_d   = (gnt_q == IDXW'(NREQ - 1)) ? '0 : gnt_q + IDXW'(1);
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      gnt_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      x_q     <= x_d;
      y_q     <= y_d;
      res_q   <= res_d;
    end
  end

  assign mul_bgn = (state_q == ISSUE);
  assign ack     = (state_q == RESP) ? (NREQ'(1) << gnt_q) : '0;
  assign result  = (state_q == RESP) ? res_q : '0;
  assign gnt_id  = gnt_q;
  assign mul_x   = x_q;
  assign mul_y   = y_q;

endmodule

// File: tb/tb_mul_arbiter.sv
// tb_mul_arbiter: directed bench for mul_arbiter (NREQ=4, W=8, TIMEOUT=63).
// A multiplier model answers 12 cycles after mul_bgn. A transaction-level
// reference model, updated once per cycle, predicts bgn/ack/result/owner
// timing from the arbitration rules; directed literal checks pin it.
module tb_mul_arbiter;

  localparam int NREQ    = 4;
  localparam int W       = 8;
  localparam int TIMEOUT = 63;

  logic              clk = 1'b0;
  logic              rst_b = 1'b0;
  logic [NREQ-1:0]   req = '0;
  logic [NREQ*W-1:0] opa = '0;
  logic [NREQ*W-1:0] opb = '0;
  logic [NREQ-1:0]   ack;
  logic [2*W-1:0]    result;
  logic [1:0]        gnt_id;
  logic              mul_bgn;
  logic [W-1:0]      mul_x;
  logic [W-1:0]      mul_y;
  logic              mul_done = 1'b0;
  logic [2*W-1:0]    mul_res = '0;
  logic              timeout_err;

  int checks = 0;
  int errors = 0;

  mul_arbiter #(.NREQ(NREQ), .W(W), .TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .rst_b       (rst_b),
    .req         (req),
    .opa         (opa),
    .opb         (opb),
    .ack         (ack),
    .result      (result),
    .gnt_id      (gnt_id),
    .mul_bgn     (mul_bgn),
    .mul_x       (mul_x),
    .mul_y       (mul_y),
    .mul_done    (mul_done),
    .mul_res     (mul_res),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endfunction

  function automatic logic [15:0] smul(input logic [7:0] a, input logic [7:0] b);
    int p;
    p = int'($signed(a)) * int'($signed(b));
    return p[15:0];
  endfunction

  // Shared multiplier: signed product, done exactly 12 cycles after bgn.
  logic        mul_en = 1'b1;
  int          mcd = 0;
  bit          mpend = 1'b0;
  logic [15:0] mprod = '0;
  initial forever begin
    @(negedge clk);
    mul_done = 1'b0;
    if (mpend) begin
      mcd--;
      if (mcd == 0) begin
        mpend    = 1'b0;
        mul_done = mul_en;
        mul_res  = mprod;
      end
    end
    if (mul_bgn) begin
      mpend = 1'b1;
      mcd   = 12;
      mprod = smul(mul_x, mul_y);
    end
  end

  // Reference model + per-cycle compare (posedge + 8).
  int          cyc = 0;
  bit          m_busy = 1'b0;
  int          m_owner = 0;
  int          m_ptr = 0;
  logic [7:0]  m_a = '0;
  logic [7:0]  m_b = '0;
  int          m_bgn = -1;
  int          m_resp = -1;
  int          m_wait = 0;
  logic [15:0] m_res = '0;
  bit          m_to = 1'b0;
  bit          do_ack;
  bit          found;
  logic [3:0]  e_ack;
  int          cand;

  initial forever begin
    @(posedge clk);
    #8;
    cyc++;
    do_ack = m_busy && (cyc == m_resp);
    e_ack  = do_ack ? (4'b0001 << m_owner) : 4'b0000;
    chk("mdl_bgn", 32'(mul_bgn), 32'(m_busy && (cyc == m_bgn)));
    chk("mdl_ack", 32'(ack), 32'(e_ack));
    chk("mdl_timeout_err", 32'(timeout_err), 32'(do_ack && m_to));
    if (do_ack) chk("mdl_result", 32'(result), 32'(m_res));
    if (m_busy) begin
      chk("mdl_gnt_id", 32'(gnt_id), 32'(m_owner));
      chk("mdl_mul_x", 32'(mul_x), 32'(m_a));
      chk("mdl_mul_y", 32'(mul_y), 32'(m_b));
    end
    // Advance model using this cycle's inputs.
    if (!rst_b) begin
      m_busy  = 1'b0;
      m_ptr   = 0;
      m_owner = 0;
    end else if (!m_busy) begin
      found = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
        cand = (m_ptr + k) % NREQ;
        if (!found && req[cand]) begin
          found   = 1'b1;
          m_owner = cand;
        end
      end
      if (found) begin
        m_a    = opa[m_owner*W +: W];
        m_b    = opb[m_owner*W +: W];
        m_busy = 1'b1;
        m_bgn  = cyc + 1;
        m_resp = -1;
        m_wait = 0;
        m_to   = 1'b0;
      end
    end else if (cyc == m_resp) begin
      m_busy = 1'b0;
      m_ptr  = (m_owner + 1) % NREQ;
    end else if (cyc > m_bgn && m_resp < 0) begin
      m_wait++;
      if (mul_done) begin
        m_resp = cyc + 1;
        m_res  = smul(m_a, m_b);
      end
`ifdef MUL_ARB_TIMEOUT_EN
      else if (m_wait == TIMEOUT) begin
        m_resp = cyc + 1;
        m_res  = '0;
        m_to   = 1'b1;
      end
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ack(input int budget, output int idx, output int el);
    idx = -1;
    el  = 0;
    while (idx < 0 && el < budget) begin
      tick();
      el++;
      for (int k = 0; k < NREQ; k++) if (ack[k]) idx = k;
    end
    chk("ack_arrived", 32'(idx >= 0), 32'd1);
    if (idx >= 0) chk("ack_onehot", 32'($countones(ack)), 32'd1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ack"}, 32'(ack), 32'd0);
    chk({tag, "_result"}, 32'(result), 32'd0);
    chk({tag, "_bgn"}, 32'(mul_bgn), 32'd0);
    chk({tag, "_mul_x"}, 32'(mul_x), 32'd0);
    chk({tag, "_mul_y"}, 32'(mul_y), 32'd0);
    chk({tag, "_gnt_id"}, 32'(gnt_id), 32'd0);
    chk({tag, "_timeout_err"}, 32'(timeout_err), 32'd0);
  endtask

  int exp_order[5] = '{0, 1, 2, 3, 0};
  int idx;
  int el;
  int nack;

  initial begin
    repeat (3) tick();
    chk_all_zero("reset");
    rst_b = 1'b1;

    // Single requester 2: 7 * -3 = -21.
    opa[2*W +: W] = 8'd7;
    opb[2*W +: W] = 8'hFD;
    req = 4'b0100;
    tick();
    chk("t1_bgn_latency", 32'(mul_bgn), 32'd1);
    repeat (12) tick();
    chk("t1_ack_not_early", 32'(ack), 32'd0);
    tick();
    chk("t1_ack", 32'(ack), 32'b0100);
    chk("t1_result", 32'(result), 32'hFFEB);
    tick();
    req = 4'b0000;

    // All four held from reset: grant order 0,1,2,3,0.
    rst_b = 1'b0;
    req = 4'b1111;
    opa = {8'h80, 8'd3, 8'hFF, 8'd10};
    opb = {8'h7F, 8'hF0, 8'hFF, 8'd12};
    repeat (2) tick();
    rst_b = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wait_ack(40, idx, el);
      chk("t2_grant_order", 32'(idx), 32'(exp_order[i]));
    end
    tick();
    req = 4'b0000;

    // Move pointer to 2, then 4'b1001 must serve 3 before 0.
    opa[1*W +: W] = 8'd5;
    opb[1*W +: W] = 8'd6;
    req = 4'b0010;
    wait_ack(40, idx, el);
    chk("t3_setup_grant", 32'(idx), 32'd1);
    tick();
    opa[0 +: W] = 8'd9;
    opb[0 +: W] = 8'hF7;
    opa[3*W +: W] = 8'd11;
    opb[3*W +: W] = 8'd13;
    req = 4'b1001;
    wait_ack(40, idx, el);
    chk("t3_first_grant", 32'(idx), 32'd3);
    chk("t3_first_result", 32'(result), 32'd143);
    tick();
    req = 4'b0001;
    wait_ack(40, idx, el);
    chk("t3_second_grant", 32'(idx), 32'd0);
    chk("t3_second_result", 32'(result), 32'hFFAF);
    tick();
    req = 4'b0000;

    // Operands changed and req dropped after grant: -5 * 9 = -45.
    opa[1*W +: W] = 8'hFB;
    opb[1*W +: W] = 8'd9;
    req = 4'b0010;
    tick();
    opa[1*W +: W] = 8'd100;
    opb[1*W +: W] = 8'd100;
    req = 4'b0000;
    wait_ack(40, idx, el);
    chk("t4_grant", 32'(idx), 32'd1);
    chk("t4_result", 32'(result), 32'hFFD3);
    tick();

    // Reset during WAIT; the late mul_done must be ignored.
    opa[3*W +: W] = 8'd3;
    opb[3*W +: W] = 8'd4;
    req = 4'b1000;
    repeat (6) tick();
    rst_b = 1'b0;
    req = 4'b0000;
    tick();
    rst_b = 1'b1;
    chk_all_zero("t5_after_reset");
    nack = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (ack != '0) nack++;
    end
    chk("t5_no_ack", 32'(nack), 32'd0);

    // Multiplier never answers.
    mul_en = 1'b0;
    opa[1*W +: W] = 8'd2;
    opb[1*W +: W] = 8'd3;
    req = 4'b0010;
    tick();
    chk("t6_bgn_from_idle", 32'(mul_bgn), 32'd1);
`ifdef MUL_ARB_TIMEOUT_EN
    wait_ack(100, idx, el);
    chk("t6_timeout_grant", 32'(idx), 32'd1);
    chk("t6_timeout_cycles", 32'(el), 32'd64);
    chk("t6_timeout_result", 32'(result), 32'd0);
    chk("t6_timeout_err", 32'(timeout_err), 32'd1);
    tick();
    req = 4'b0000;
`else
    nack = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (ack != '0) nack++;
    end
    chk("t6_no_ack_without_timeout", 32'(nack), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
